// File: rtl/wb_dma_pkg.sv
// Shared types and defaults for the byte-wide Wishbone DMA initiator.
package wb_dma_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_RGAP = 3'd2,
        S_WR   = 3'd3,
        S_WGAP = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_LEN_W  = 10;
    localparam int DEF_TMO    = 255;

endpackage

// File: rtl/wbm_watchdog.sv
// Access watchdog: counts cycles spent waiting for an ACK.
module wbm_watchdog #(
    parameter int TMO = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TMO + 1);
    localparam logic [CW-1:0] LIM = CW'(TMO - 1);

    logic [CW-1:0] r_cnt;

    // Saturates at the limit so a stalled access keeps reporting expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && r_cnt != LIM) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign expired = en && (r_cnt == LIM);

endmodule

// File: rtl/wb_dma_master.sv
// Wishbone classic byte-copy initiator: one read then one write per byte.
module wb_dma_master
    import wb_dma_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int TMO    = DEF_TMO
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  remain,
    output logic [ADDR_W-1:0] WB_ADRo,
    output logic [7:0]        WB_DATo,
    input  logic [7:0]        WB_DATi,
    output logic              WB_WEo,
    output logic              WB_CYCo,
    output logic              WB_STBo,
    input  logic              WB_ACKi
);

    state_t r_state;
    state_t w_next;

    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W-1:0] r_adr;
    logic [LEN_W-1:0]  r_remain;
    logic [7:0]        r_buf;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_cyc;
    logic              r_we;

    logic w_accept;
    logic w_active;
    logic w_ack;
    logic w_expired;
    logic w_tmo;

    assign w_accept = start && !r_busy && (r_state == S_IDLE);
    assign w_active = (r_state == S_RD) || (r_state == S_WR);
    assign w_ack    = WB_ACKi && w_active;
    assign w_tmo    = w_expired && !w_ack;

    wbm_watchdog #(
        .TMO(TMO)
    ) u_wdg (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_next != r_state),
        .en     (w_active),
        .expired(w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // An ACK on the abort/timeout cycle still completes the access.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (len == '0) ? S_FIN : S_RD;
                end
            end
            S_RD: begin
                if (w_ack) begin
                    w_next = abort ? S_FIN : S_RGAP;
                end else if (abort || w_tmo) begin
                    w_next = S_FIN;
                end
            end
            S_RGAP: w_next = abort ? S_FIN : S_WR;
            S_WR: begin
                if (w_ack) begin
                    w_next = abort ? S_FIN : S_WGAP;
                end else if (abort || w_tmo) begin
                    w_next = S_FIN;
                end
            end
            S_WGAP: w_next = (abort || r_remain == '0) ? S_FIN : S_RD;
            S_FIN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src    <= '0;
            r_dst    <= '0;
            r_adr    <= '0;
            r_remain <= '0;
            r_buf    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_cyc    <= 1'b0;
            r_we     <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIN);
            r_cyc  <= (w_next == S_RD) || (w_next == S_WR);
            r_we   <= (w_next == S_WR);
            if (w_accept) begin
                r_src    <= src;
                r_dst    <= dst;
                r_remain <= len;
                r_err    <= 1'b0;
                r_busy   <= 1'b1;
            end else if (r_done) begin
                r_busy <= 1'b0;
            end
            if (r_state == S_RD && w_ack) begin
                r_buf <= WB_DATi;
            end
            if (r_state == S_WR && w_ack) begin
                r_src    <= r_src + ADDR_W'(1);
                r_dst    <= r_dst + ADDR_W'(1);
                r_remain <= r_remain - LEN_W'(1);
            end
            if (w_tmo) begin
                r_err <= 1'b1;
            end
            // Address only moves on access entry, so it is steady under STB.
            if (w_next == S_RD && r_state != S_RD) begin
                r_adr <= (r_state == S_IDLE) ? src : r_src;
            end
            if (w_next == S_WR && r_state != S_WR) begin
                r_adr <= r_dst;
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign remain  = r_remain;
    assign WB_ADRo = r_adr;
    assign WB_DATo = r_buf;
    assign WB_WEo  = r_we;
    assign WB_CYCo = r_cyc;
    assign WB_STBo = r_cyc;

endmodule

// File: tb/tb_wb_dma_master.sv
// Scoreboard bench for wb_dma_master against a byte-copy reference model.
module tb_wb_dma_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] src = '0;
    logic [15:0] dst = '0;
    logic [9:0]  len = '0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic [9:0]  remain;
    logic [15:0] WB_ADRo;
    logic [7:0]  WB_DATo;
    logic [7:0]  WB_DATi;
    logic        WB_WEo;
    logic        WB_CYCo;
    logic        WB_STBo;
    logic        WB_ACKi;

    localparam int TMO_T = 8;

    wb_dma_master #(
        .ADDR_W(16),
        .LEN_W (10),
        .TMO   (TMO_T)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .src    (src),
        .dst    (dst),
        .len    (len),
        .abort  (abort),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .remain (remain),
        .WB_ADRo(WB_ADRo),
        .WB_DATo(WB_DATo),
        .WB_DATi(WB_DATi),
        .WB_WEo (WB_WEo),
        .WB_CYCo(WB_CYCo),
        .WB_STBo(WB_STBo),
        .WB_ACKi(WB_ACKi)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [15:0] adr;
        logic [7:0]  dat;
    } acc_t;

    typedef struct {
        int   rem;
        logic er;
        int   lat;
    } fin_t;

    acc_t exp_acc[$];
    fin_t exp_fin[$];

    logic [7:0] mem     [65536];
    logic [7:0] ref_mem [65536];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_start = 0;
    int n_rd    = 0;
    int slv_wait = 0;
    bit mute_wr  = 0;
    bit cyc_seen = 0;
    bit gap_pend = 0;
    bit stb_prev = 0;
    logic [24:0] hold = '0;
    int wcnt = 0;
    logic ack_r = 1'b0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Registered-ACK slave: ACK follows STB, so it lingers one cycle stale.
    assign WB_ACKi = ack_r;
    assign WB_DATi = mem[WB_ADRo];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_r <= 1'b0;
            wcnt  <= 0;
        end else if (WB_CYCo && WB_STBo) begin
            if (mute_wr && WB_WEo) ack_r <= 1'b0;
            else if (wcnt >= slv_wait) ack_r <= 1'b1;
            else wcnt <= wcnt + 1;
        end else begin
            ack_r <= 1'b0;
            wcnt  <= 0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            stb_prev = 0;
            gap_pend = 0;
        end else begin
            if (gap_pend) begin
                check("gap_cyc", 32'(WB_CYCo), 0);
                gap_pend = 0;
            end
            if (WB_STBo && stb_prev)
                check("stable", 32'({WB_ADRo, WB_WEo, WB_DATo}), 32'(hold));
            stb_prev = WB_STBo;
            hold = {WB_ADRo, WB_WEo, WB_DATo};
            if (WB_CYCo) cyc_seen = 1;
            if (WB_CYCo && WB_STBo && WB_ACKi) begin
                if (exp_acc.size() == 0) begin
                    check("acc_unexp", 32'(WB_ADRo), 32'hFFFF_FFFF);
                end else begin
                    acc_t e;
                    e = exp_acc.pop_front();
                    check("acc_we", 32'(WB_WEo), 32'(e.we));
                    check("acc_adr", 32'(WB_ADRo), 32'(e.adr));
                    if (e.we) check("acc_dat", 32'(WB_DATo), 32'(e.dat));
                end
                if (WB_WEo) mem[WB_ADRo] = WB_DATo;
                else n_rd++;
                gap_pend = 1;
            end
            if (done) begin
                if (exp_fin.size() == 0) begin
                    check("done_unexp", 1, 0);
                end else begin
                    fin_t f;
                    f = exp_fin.pop_front();
                    check("fin_remain", 32'(remain), 32'(f.rem));
                    check("fin_err", 32'(err), 32'(f.er));
                    check("fin_busy", 32'(busy), 1);
                    check("fin_cyc", 32'(WB_CYCo), 0);
                    if (f.lat >= 0) check("fin_lat", 32'(cyc - t_start), 32'(f.lat));
                end
            end
        end
    end

    // Reference copy: byte i goes from src+i to dst+i, in order.
    task automatic push_bytes(input logic [15:0] s, input logic [15:0] d,
                              input int n);
        for (int i = 0; i < n; i++) begin
            logic [15:0] a;
            logic [15:0] b;
            logic [7:0]  v;
            a = s + 16'(i);
            b = d + 16'(i);
            v = ref_mem[a];
            exp_acc.push_back(acc_t'{we: 1'b0, adr: a, dat: 8'h00});
            exp_acc.push_back(acc_t'{we: 1'b1, adr: b, dat: v});
            ref_mem[b] = v;
        end
    endtask

    task automatic push_fin(input int r, input logic e, input int l);
        fin_t f;
        f.rem = r;
        f.er  = e;
        f.lat = l;
        exp_fin.push_back(f);
    endtask

    task automatic launch(input logic [15:0] s, input logic [15:0] d,
                          input logic [9:0] l, input int w, input bit ab);
        int k;
        k = 0;
        @(negedge clk);
        while ((busy || done) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) check("idle_tmo", 1, 0);
        slv_wait = w;
        n_rd = 0;
        cyc_seen = 0;
        start = 1'b1;
        src = s;
        dst = d;
        len = l;
        abort = ab;
        t_start = cyc;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        src = 16'($urandom);
        dst = 16'($urandom);
        len = 10'($urandom);
        #1;
        check("busy_rise", 32'(busy), 1);
        check("err_clr", 32'(err), 0);
    endtask

    task automatic wait_fin();
        int k;
        k = 0;
        while (exp_fin.size() != 0 && k < 2000) begin
            @(posedge clk);
            k++;
        end
        if (k >= 2000) begin
            check("done_tmo", 0, 1);
            exp_fin.delete();
        end
        check("acc_left", 32'(exp_acc.size()), 0);
        exp_acc.delete();
    endtask

    task automatic xfer(input logic [15:0] s, input logic [15:0] d,
                        input int l, input int w, input bit mid, input bit ab);
        push_bytes(s, d, l);
        push_fin(0, 1'b0, (6 + 2 * w) * l + 2);
        launch(s, d, 10'(l), w, ab);
        if (mid && l > 0) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            src = 16'($urandom);
            dst = 16'($urandom);
            len = 10'($urandom_range(1, 20));
            @(negedge clk);
            start = 1'b0;
        end
        wait_fin();
        if (l == 0) check("zl_nocyc", 32'(cyc_seen), 0);
    endtask

    task automatic wait_until_rd2();
        int k;
        k = 0;
        while (!(n_rd == 1 && WB_CYCo && !WB_WEo && !WB_ACKi) && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (k >= 200) check("rd2_tmo", 0, 1);
    endtask

    task automatic wait_until_wack();
        int k;
        k = 0;
        while (!(WB_CYCo && WB_WEo && WB_ACKi) && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (k >= 200) check("wack_tmo", 0, 1);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (3) @(negedge clk);
        #1;
        check("reset_vals",
              32'({busy, done, err, remain, WB_CYCo, WB_STBo, WB_WEo}), 0);
        check("reset_bus", 32'({WB_ADRo, WB_DATo}), 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic copy
        mem[16'h0010] = 8'hA5; ref_mem[16'h0010] = 8'hA5;
        mem[16'h0011] = 8'h5A; ref_mem[16'h0011] = 8'h5A;
        mem[16'h0012] = 8'h3C; ref_mem[16'h0012] = 8'h3C;
        xfer(16'h0010, 16'h0100, 3, 0, 0, 0);
        check("basic_m0", 32'(mem[16'h0100]), 32'hA5);
        check("basic_m1", 32'(mem[16'h0101]), 32'h5A);
        check("basic_m2", 32'(mem[16'h0102]), 32'h3C);
        check("basic_rem", 32'(remain), 0);

        // Zero length, then start pulses while busy
        xfer(16'h1234, 16'h4321, 0, 0, 0, 0);
        xfer(16'h0200, 16'h0300, 4, 1, 1, 0);

        // Address wrap
        xfer(16'hFFFF, 16'h7FFF, 2, 0, 0, 0);

        // Timeout on the first write
        mute_wr = 1;
        exp_acc.push_back(acc_t'{we: 1'b0, adr: 16'h0400, dat: 8'h00});
        push_fin(2, 1'b1, -1);
        launch(16'h0400, 16'h0500, 10'd2, 0, 0);
        wait_fin();
        mute_wr = 0;
        #1;
        check("err_sticky", 32'(err), 1);
        check("tmo_bus", 32'(WB_CYCo), 0);
        xfer(16'h0600, 16'h0700, 1, 0, 0, 0);

        // Abort during the second read
        push_bytes(16'h0800, 16'h0900, 1);
        push_fin(3, 1'b0, -1);
        launch(16'h0800, 16'h0900, 10'd4, 1, 0);
        wait_until_rd2();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_fin();

        // Abort coincident with a write ACK
        push_bytes(16'h0A00, 16'h0B00, 1);
        push_fin(2, 1'b0, -1);
        launch(16'h0A00, 16'h0B00, 10'd3, 0, 0);
        wait_until_wack();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_fin();

        // Reset while STB is high
        launch(16'h0C00, 16'h0D00, 10'd3, 2, 0);
        begin
            int k;
            k = 0;
            while (!WB_STBo && k < 50) begin
                @(negedge clk);
                k++;
            end
            if (k >= 50) check("rst_stb_tmo", 0, 1);
        end
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_bus", 32'({WB_CYCo, WB_STBo, WB_WEo}), 0);
        check("rst_async_st", 32'({busy, done, err, remain}), 0);
        check("rst_async_ad", 32'({WB_ADRo, WB_DATo}), 0);
        @(negedge clk);
        rst = 1'b0;
        exp_acc.delete();
        exp_fin.delete();
        xfer(16'h0C00, 16'h0D00, 3, 0, 0, 0);

        // Randomized transfers
        for (int t = 0; t < 16; t++) begin
            xfer(16'($urandom), 16'($urandom), $urandom_range(0, 6),
                 $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
